s32x_dreq_ctrl: RTL and testbench
=================================

# s32x_dreq_ctrl

Controller for the 32X 68000-to-SH2 DREQ transfer path (DCR/DLR/FFDR register set at A15106/A15110/A15112). It owns the 8-word FFDR FIFO, the remaining-length counter and the M68S/FULL status bits. It raises DREQ0 toward the master SH2 DMAC whenever a complete 4-word block is ready. It sits between the 68k-side system register decoder and the SH2 DREQ0 pin / 20004012 read port.

## Interface
Parameters:
- FIFO_WORDS, 8, FIFO depth in 16-bit words; must be 2×BLK_WORDS
- BLK_WORDS, 4, words per DREQ burst; power of two

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous, active-high reset
- EN  in  1  clock enable; all state advances only when EN=1
- DCR_WR  in  1  68k write strobe to DCR
- DCR_DI  in  3  {M68S, DMA, RV} write data (DCR bits 2..0)
- DLR_WR  in  1  68k write strobe to DLR
- DLR_DI  in  16  transfer length in words; bits [1:0] forced to 0
- FFDR_WR  in  1  68k write strobe to FFDR
- FFDR_DI  in  16  FIFO write data
- FIFO_RD  in  1  SH2 read strobe of 20004012
- FIFO_DO  out  16  word at FIFO head
- DREQ  out  1  DREQ0 to master SH2
- M68S  out  1  transfer-active status bit
- DMA  out  1  stored DMA bit
- RV  out  1  stored RV bit (ROM-view to SH2)
- FULL  out  1  DCR.FULL
- DLR_CNT  out  16  words remaining to be written by 68k
- DONE  out  1  one-cycle pulse at transfer completion

## Operation
- States: IDLE, ACTIVE, DRAIN. Reset state is IDLE.
- DLR register: a DLR_WR stores DLR_DI & 16'hFFFC. It is loadable in any state, but only sampled on start.
- DCR_WR always stores DMA and RV.
- In IDLE, DCR_WR with M68S=1 does the following: DLR_CNT←DLR; FIFO pointers and count are cleared; go to ACTIVE. If DLR==0, go straight to DRAIN instead; DRAIN then completes on the next cycle.
- DCR_WR with M68S=0 in ACTIVE or DRAIN is an abort: flush the FIFO, set DLR_CNT←0, go to IDLE, no DONE pulse.
- ACTIVE, FFDR_WR:
  - If count<FIFO_WORDS, write the word at wr_ptr, wr_ptr++, count++, DLR_CNT--.
  - If count==FIFO_WORDS, the word is dropped and no state changes.
  - When DLR_CNT reaches 0, go to DRAIN.
- FFDR_WR in IDLE or DRAIN is ignored.
- FIFO_RD with count>0 advances rd_ptr and decrements count. FIFO_RD with count==0 is ignored; FIFO_DO holds its value.
- FFDR_WR and FIFO_RD in the same cycle: both act and count is unchanged. At count==FIFO_WORDS with both present, the write is accepted because a read is occurring.
- DRAIN: when count reaches 0, go to IDLE and pulse DONE.
- Pointers are log2(FIFO_WORDS) bits wide and wrap modulo FIFO_WORDS.
- M68S = (state != IDLE).
- FULL = (count == FIFO_WORDS).
- DREQ = (count ≥ BLK_WORDS) && (rd_ptr mod BLK_WORDS == 0) && state != IDLE. DREQ therefore drops during a burst and re-evaluates at block boundaries.
- FIFO_DO = mem[rd_ptr], combinational from the registered array.

## Timing
- Reset values: all outputs are 0; DLR=0, pointers=0, count=0.
- Reset takes priority over EN and all strobes.
- M68S, DLR_CNT, FULL and DREQ are registered; each updates on the edge that captures the causing strobe.
  - DREQ is high in the cycle after the edge that accepted the 4th word of a block.
- FIFO_DO reflects a new head in the cycle after a FIFO_RD edge.
- DONE is high for exactly one EN cycle, the cycle after the final read edge.
- Abort and DCR start are precedence over same-cycle FFDR_WR/FIFO_RD: strobes coinciding with DCR_WR are discarded.
- Strobes with EN=0 are ignored; they are not queued.

## Test plan
- DLR=8, start, 8 FFDR writes 0x1111..0x8888, SH2 idle -> DREQ=1 after write 4; FULL=1 after write 8; DLR_CNT=0; state DRAIN; a 9th write is ignored.
- Continue: 8 FIFO_RDs -> data 0x1111..0x8888 in order; DREQ low during reads 1-3, high again after read 4, low after read 8; DONE pulse; M68S=0.
- DLR=0x0007 -> DLR reads back 4; start with 4 writes -> 4 words accepted, DONE after 4 reads.
- FIFO at 8 words with simultaneous FFDR_WR and FIFO_RD -> write accepted, count stays 8, pointer wrap is correct.
- Mid-transfer DCR_WR M68S=0 after 3 writes -> count=0, DREQ=0, M68S=0, no DONE; a subsequent FIFO_RD is ignored.
- RST asserted in ACTIVE with DREQ=1 -> next cycle all outputs 0, DLR=0; start without a DLR write -> DONE one cycle after DRAIN.

Source files
------------

// File: rtl/s32x_dreq_ctrl.sv
// rtl/s32x_dreq_ctrl.sv - 32X 68000-to-SH2 DREQ transfer controller (DCR/DLR/FFDR)
//
// Owns the FFDR FIFO, the remaining-length counter and the DCR status bits.
// DREQ0 is raised toward the master SH2 whenever a full block is buffered
// and the read pointer sits on a block boundary.
//
// Ports:
//   CLK, RST, EN        clock, synchronous active-high reset, clock enable
//   DCR_WR / DCR_DI     68k DCR write {M68S, DMA, RV}
//   DLR_WR / DLR_DI     68k DLR write (length in words, low two bits dropped)
//   FFDR_WR / FFDR_DI   68k FIFO data write
//   FIFO_RD             SH2 read strobe of the FIFO port
//   FIFO_DO             word at FIFO head
//   DREQ                DREQ0 to master SH2
//   M68S, DMA, RV, FULL DCR status / stored bits
//   DLR_CNT             words still to be written by the 68k
//   DONE                one-cycle pulse when the transfer completes
module s32x_dreq_ctrl #(
    parameter int FIFO_WORDS = 8,
    parameter int BLK_WORDS  = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        EN,
    input  logic        DCR_WR,
    input  logic [2:0]  DCR_DI,
    input  logic        DLR_WR,
    input  logic [15:0] DLR_DI,
    input  logic        FFDR_WR,
    input  logic [15:0] FFDR_DI,
    input  logic        FIFO_RD,
    output logic [15:0] FIFO_DO,
    output logic        DREQ,
    output logic        M68S,
    output logic        DMA,
    output logic        RV,
    output logic        FULL,
    output logic [15:0] DLR_CNT,
    output logic        DONE
);

    localparam int PW = $clog2(FIFO_WORDS);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH    = CW'(FIFO_WORDS);
    localparam logic [CW-1:0] BLK      = CW'(BLK_WORDS);
    localparam logic [PW-1:0] BLK_MASK = PW'(BLK_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DRAIN  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     dlr_q, dlr_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            dma_q, dma_d;
    logic            rv_q, rv_d;
    logic            full_q, full_d;
    logic            dreq_q, dreq_d;
    logic            done_q, done_d;
    logic [15:0]     mem_q [FIFO_WORDS];
    logic            mem_we;
    logic            rd_ok;
    logic            wr_ok;

    always_comb begin
        state_d  = state_q;
        dlr_d    = dlr_q;
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dma_d    = dma_q;
        rv_d     = rv_q;
        done_d   = 1'b0;
        mem_we   = 1'b0;
        rd_ok    = 1'b0;
        wr_ok    = 1'b0;

        if (DLR_WR) begin
            dlr_d = DLR_DI & 16'hFFFC;
        end

        if (DCR_WR) begin
            // A DCR write owns the cycle: same-cycle FIFO strobes are dropped.
            dma_d = DCR_DI[1];
            rv_d  = DCR_DI[0];
            if (DCR_DI[2]) begin
                if (state_q == S_IDLE) begin
                    // Start samples the DLR value held before this cycle.
                    cnt_d    = dlr_q;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    count_d  = '0;
                    state_d  = (dlr_q == 16'd0) ? S_DRAIN : S_ACTIVE;
                end
            end else if (state_q != S_IDLE) begin
                cnt_d    = 16'd0;
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                count_d  = '0;
                state_d  = S_IDLE;
            end
        end else begin
            rd_ok = FIFO_RD && (count_q != '0);
            // A read in the same cycle frees a slot, so a full FIFO still accepts.
            wr_ok = FFDR_WR && (state_q == S_ACTIVE) && ((count_q != DEPTH) || rd_ok);
            if (rd_ok) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (wr_ok) begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
                cnt_d    = cnt_q - 16'd1;
            end
            count_d = count_q + CW'(wr_ok) - CW'(rd_ok);

            if ((state_q == S_ACTIVE) && (cnt_d == 16'd0)) begin
                state_d = S_DRAIN;
            end
            if ((state_q == S_DRAIN) && (count_d == '0)) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
        end

        full_d = (count_d == DEPTH);
        dreq_d = (count_d >= BLK) && ((rd_ptr_d & BLK_MASK) == '0) && (state_d != S_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            dlr_q    <= 16'd0;
            cnt_q    <= 16'd0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dma_q    <= 1'b0;
            rv_q     <= 1'b0;
            full_q   <= 1'b0;
            dreq_q   <= 1'b0;
            done_q   <= 1'b0;
            for (int i = 0; i < FIFO_WORDS; i++) begin
                mem_q[i] <= 16'd0;
            end
        end else if (EN) begin
            state_q  <= state_d;
            dlr_q    <= dlr_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dma_q    <= dma_d;
            rv_q     <= rv_d;
            full_q   <= full_d;
            dreq_q   <= dreq_d;
            done_q   <= done_d;
            if (mem_we) begin
                mem_q[wr_ptr_q] <= FFDR_DI;
            end
        end
    end

    assign FIFO_DO = mem_q[rd_ptr_q];
    assign DREQ    = dreq_q;
    assign M68S    = (state_q != S_IDLE);
    assign DMA     = dma_q;
    assign RV      = rv_q;
    assign FULL    = full_q;
    assign DLR_CNT = cnt_q;
    assign DONE    = done_q;

endmodule

// File: tb/tb_s32x_dreq_ctrl.sv
// tb/tb_s32x_dreq_ctrl.sv - self-checking bench for s32x_dreq_ctrl
module tb_s32x_dreq_ctrl;

    localparam int DEPTH = 8;
    localparam int BLK   = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        EN = 1'b0;
    logic        DCR_WR = 1'b0;
    logic [2:0]  DCR_DI = 3'd0;
    logic        DLR_WR = 1'b0;
    logic [15:0] DLR_DI = 16'd0;
    logic        FFDR_WR = 1'b0;
    logic [15:0] FFDR_DI = 16'd0;
    logic        FIFO_RD = 1'b0;
    logic [15:0] FIFO_DO;
    logic        DREQ, M68S, DMA, RV, FULL, DONE;
    logic [15:0] DLR_CNT;

    s32x_dreq_ctrl #(.FIFO_WORDS(DEPTH), .BLK_WORDS(BLK)) dut (
        .CLK(CLK), .RST(RST), .EN(EN),
        .DCR_WR(DCR_WR), .DCR_DI(DCR_DI),
        .DLR_WR(DLR_WR), .DLR_DI(DLR_DI),
        .FFDR_WR(FFDR_WR), .FFDR_DI(FFDR_DI),
        .FIFO_RD(FIFO_RD), .FIFO_DO(FIFO_DO),
        .DREQ(DREQ), .M68S(M68S), .DMA(DMA), .RV(RV),
        .FULL(FULL), .DLR_CNT(DLR_CNT), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    int vectors = 0;
    int miscompares = 0;
    bit chk_on = 1'b0;

    // Reference model: words written/read as running totals, a transfer
    // that is busy and may be in its draining phase.
    int          m_wr, m_rd, m_rem;
    bit          m_busy, m_drain, m_done, m_dma, m_rv;
    logic [15:0] m_dlr;
    logic [15:0] m_mem [DEPTH];

    task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_wr = 0; m_rd = 0; m_rem = 0;
        m_busy = 0; m_drain = 0; m_done = 0; m_dma = 0; m_rv = 0;
        m_dlr = 16'd0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 16'd0;
    endtask

    task automatic model_apply();
        logic [15:0] old_dlr;
        bit was_drain;
        bit rd, wr;
        int n;
        if (RST) begin
            model_reset();
        end else if (EN) begin
            old_dlr   = m_dlr;
            was_drain = m_drain;
            n         = m_wr - m_rd;
            m_done    = 0;
            if (DLR_WR) m_dlr = DLR_DI & 16'hFFFC;
            if (DCR_WR) begin
                m_dma = DCR_DI[1];
                m_rv  = DCR_DI[0];
                if (DCR_DI[2] && !m_busy) begin
                    m_rem = int'(old_dlr); m_wr = 0; m_rd = 0;
                    m_busy = 1; m_drain = (old_dlr == 16'd0);
                end else if (!DCR_DI[2] && m_busy) begin
                    m_rem = 0; m_wr = 0; m_rd = 0; m_busy = 0; m_drain = 0;
                end
            end else begin
                rd = FIFO_RD && (n > 0);
                wr = FFDR_WR && m_busy && !m_drain && ((n < DEPTH) || rd);
                if (wr) begin
                    m_mem[m_wr % DEPTH] = FFDR_DI;
                    m_wr++;
                    m_rem--;
                    if (m_rem == 0) m_drain = 1;
                end
                if (rd) m_rd++;
                if (was_drain && (m_wr == m_rd)) begin
                    m_busy = 0; m_drain = 0; m_done = 1;
                end
            end
        end
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge CLK) begin
        int n;
        if (chk_on) begin
            n = m_wr - m_rd;
            chk("FIFO_DO", FIFO_DO, m_mem[m_rd % DEPTH]);
            chk("DREQ", {15'd0, DREQ}, {15'd0, (n >= BLK) && (m_rd % BLK == 0) && m_busy});
            chk("M68S", {15'd0, M68S}, {15'd0, m_busy});
            chk("DMA", {15'd0, DMA}, {15'd0, m_dma});
            chk("RV", {15'd0, RV}, {15'd0, m_rv});
            chk("FULL", {15'd0, FULL}, {15'd0, n == DEPTH});
            chk("DLR_CNT", DLR_CNT, m_rem[15:0]);
            chk("DONE", {15'd0, DONE}, {15'd0, m_done});
        end
    end

    task automatic step(bit rst, bit en, bit dcrw, logic [2:0] dcrd, bit dlrw,
                        logic [15:0] dlrd, bit fw, logic [15:0] fd, bit fr);
        @(negedge CLK);
        #1;
        RST = rst; EN = en; DCR_WR = dcrw; DCR_DI = dcrd; DLR_WR = dlrw;
        DLR_DI = dlrd; FFDR_WR = fw; FFDR_DI = fd; FIFO_RD = fr;
        @(posedge CLK);
        model_apply();
        #1;
    endtask

    task automatic do_reset();  step(1, 0, 0, 3'd0, 0, 16'd0, 0, 16'd0, 0); endtask
    task automatic idle();      step(0, 1, 0, 3'd0, 0, 16'd0, 0, 16'd0, 0); endtask
    task automatic wr_dlr(logic [15:0] v); step(0, 1, 0, 3'd0, 1, v, 0, 16'd0, 0); endtask
    task automatic wr_dcr(logic [2:0] v);  step(0, 1, 1, v, 0, 16'd0, 0, 16'd0, 0); endtask
    task automatic wr_ffdr(logic [15:0] d); step(0, 1, 0, 3'd0, 0, 16'd0, 1, d, 0); endtask
    task automatic rd_fifo();   step(0, 1, 0, 3'd0, 0, 16'd0, 0, 16'd0, 1); endtask
    task automatic wr_rd(logic [15:0] d);  step(0, 1, 0, 3'd0, 0, 16'd0, 1, d, 1); endtask

    initial begin
        logic [15:0] w;
        model_reset();
        do_reset();
        chk_on = 1'b1;
        chk("rst DLR_CNT", DLR_CNT, 16'd0);
        chk("rst flags", {10'd0, DREQ, M68S, DMA, RV, FULL, DONE}, 16'd0);
        chk("rst FIFO_DO", FIFO_DO, 16'd0);

        // Full 8-word transfer, SH2 idle while filling.
        wr_dlr(16'd8);
        wr_dcr(3'b101);
        chk("start M68S", {15'd0, M68S}, 16'd1);
        chk("start RV", {15'd0, RV}, 16'd1);
        chk("start DLR_CNT", DLR_CNT, 16'd8);
        for (int k = 1; k <= 8; k++) begin
            w = 16'h1111 * k[15:0];
            wr_ffdr(w);
            if (k == 3) chk("DREQ after 3 writes", {15'd0, DREQ}, 16'd0);
            if (k == 4) chk("DREQ after 4 writes", {15'd0, DREQ}, 16'd1);
        end
        chk("FULL after 8", {15'd0, FULL}, 16'd1);
        chk("DLR_CNT after 8", DLR_CNT, 16'd0);
        wr_ffdr(16'h9999);
        chk("9th write dropped", FIFO_DO, 16'h1111);
        chk("FULL held", {15'd0, FULL}, 16'd1);
        for (int k = 1; k <= 8; k++) begin
            w = 16'h1111 * k[15:0];
            chk("read data", FIFO_DO, w);
            rd_fifo();
            if (k < 4 || (k > 4 && k < 8)) chk("DREQ mid burst", {15'd0, DREQ}, 16'd0);
            if (k == 4) chk("DREQ block boundary", {15'd0, DREQ}, 16'd1);
        end
        chk("DONE pulse", {15'd0, DONE}, 16'd1);
        chk("M68S end", {15'd0, M68S}, 16'd0);
        idle();
        chk("DONE one cycle", {15'd0, DONE}, 16'd0);

        // DLR low bits are dropped.
        wr_dlr(16'h0007);
        wr_dcr(3'b100);
        chk("DLR 7 -> 4", DLR_CNT, 16'd4);
        for (int k = 0; k < 4; k++) wr_ffdr(16'h5000 + k[15:0]);
        chk("DREQ 4 words", {15'd0, DREQ}, 16'd1);
        for (int k = 0; k < 4; k++) rd_fifo();
        chk("DONE after 4", {15'd0, DONE}, 16'd1);

        // Full FIFO with simultaneous write and read wraps the write pointer.
        wr_dlr(16'd16);
        wr_dcr(3'b100);
        for (int k = 1; k <= 8; k++) wr_ffdr(16'h2000 + k[15:0]);
        wr_rd(16'hAAAA);
        chk("wrap FULL", {15'd0, FULL}, 16'd1);
        chk("wrap head", FIFO_DO, 16'h2002);
        for (int k = 0; k < 7; k++) rd_fifo();
        chk("wrapped word", FIFO_DO, 16'hAAAA);
        chk("wrap DLR_CNT", DLR_CNT, 16'd7);
        wr_dcr(3'b000);

        // Abort mid-transfer.
        wr_dlr(16'd8);
        wr_dcr(3'b110);
        for (int k = 1; k <= 3; k++) wr_ffdr(16'h3000 + k[15:0]);
        wr_dcr(3'b010);
        chk("abort flags", {10'd0, DREQ, M68S, DMA, RV, FULL, DONE}, 16'b0000_0000_0000_1000);
        chk("abort DLR_CNT", DLR_CNT, 16'd0);
        rd_fifo();
        chk("read after abort", FIFO_DO, 16'h3001);
        chk("no DONE on abort", {15'd0, DONE}, 16'd0);

        // Reset while DREQ is high, then start with DLR cleared.
        wr_dcr(3'b100);
        for (int k = 0; k < 4; k++) wr_ffdr(16'h4000 + k[15:0]);
        chk("pre-reset DREQ", {15'd0, DREQ}, 16'd1);
        do_reset();
        chk("reset flags", {10'd0, DREQ, M68S, DMA, RV, FULL, DONE}, 16'd0);
        chk("reset FIFO_DO", FIFO_DO, 16'd0);
        wr_dcr(3'b100);
        chk("zero-length M68S", {15'd0, M68S}, 16'd1);
        idle();
        chk("zero-length DONE", {15'd0, DONE}, 16'd1);
        chk("zero-length idle", {15'd0, M68S}, 16'd0);

        // Randomised traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            logic [15:0] dl;
            dl = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 40));
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 9) != 0,
                 $urandom_range(0, 24) == 0,
                 3'($urandom),
                 $urandom_range(0, 14) == 0,
                 dl,
                 $urandom_range(0, 2) != 0,
                 16'($urandom),
                 $urandom_range(0, 2) == 0);
        end

        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
